// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types and defaults for the pipeline accelerator sink stage.
package pp_pipeline_accel_pkg;

  localparam int unsigned DefDataW = 24;
  localparam int unsigned DefDimW  = 32;

  // Held-done register values for the ap_ctrl_chain handshake.
  localparam logic ApDoneHeld  = 1'b1;
  localparam logic ApDoneClear = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StDims,
    StStream,
    StDrain,
    StDone
  } sink_state_e;

endpackage

// File: rtl/pp_pipeline_accel_axis_out_reg.sv
// One-entry AXI4-Stream output register: a load replaces the entry, a handshake
// without a load empties it, and the payload is held while stalled.
module pp_pipeline_accel_axis_out_reg
  import pp_pipeline_accel_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              user_in,
  input  logic              last_in,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tuser,
  output logic              tlast
);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= din;
      tuser  <= user_in;
      tlast  <= last_in;
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_mat2axis_sink.sv
// Reads frame dimensions, drains rows*cols pixels into an AXI4-Stream video master
// (tuser = start of frame, tlast = end of line) under ap_ctrl_chain control.
module pp_pipeline_accel_mat2axis_sink
  import pp_pipeline_accel_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIM_W  = DefDimW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DIM_W-1:0]  rows_c_dout,
  input  logic              rows_c_empty_n,
  output logic              rows_c_read,
  input  logic [DIM_W-1:0]  cols_c_dout,
  input  logic              cols_c_empty_n,
  output logic              cols_c_read,
  input  logic [DATA_W-1:0] data_dout,
  input  logic              data_empty_n,
  output logic              data_read,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast
);

  sink_state_e      state;
  logic             done_reg;
  logic [DIM_W-1:0] rows_q, cols_q, row_q, col_q;
  logic             dims_ok, load, col_last, row_last, first_px;

  assign dims_ok     = rows_c_empty_n & cols_c_empty_n;
  // Both dimension channels are always popped together.
  assign rows_c_read = (state == StDims) & dims_ok;
  assign cols_c_read = (state == StDims) & dims_ok;

  assign load      = (state == StStream) & data_empty_n & (~m_axis_tvalid | m_axis_tready);
  assign data_read = load;

  // Only meaningful in StStream, where both dimensions are non-zero.
  assign col_last = (col_q == cols_q - DIM_W'(1));
  assign row_last = (row_q == rows_q - DIM_W'(1));
  assign first_px = (row_q == '0) & (col_q == '0);

  assign ap_done  = (state == StDone) | done_reg;
  assign ap_ready = (state == StDone);
  assign ap_idle  = (state == StIdle) & ~ap_start;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= StIdle;
      done_reg <= ApDoneClear;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      if (ap_continue) done_reg <= ApDoneClear;
      unique case (state)
        StIdle: begin
          if (ap_start && !done_reg) state <= StDims;
        end
        StDims: begin
          if (dims_ok) begin
            rows_q <= rows_c_dout;
            cols_q <= cols_c_dout;
            row_q  <= '0;
            col_q  <= '0;
            state  <= (rows_c_dout == '0 || cols_c_dout == '0) ? StDone : StStream;
          end
        end
        StStream: begin
          if (load) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + DIM_W'(1);
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
            if (col_last && row_last) state <= StDrain;
          end
        end
        StDrain: begin
          if (m_axis_tvalid && m_axis_tready) state <= StDone;
        end
        StDone: begin
          state <= StIdle;
          if (!ap_continue) done_reg <= ApDoneHeld;
        end
        default: state <= StIdle;
      endcase
    end
  end

  pp_pipeline_accel_axis_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .load    (load),
    .din     (data_dout),
    .user_in (first_px),
    .last_in (col_last),
    .tready  (m_axis_tready),
    .tdata   (m_axis_tdata),
    .tvalid  (m_axis_tvalid),
    .tuser   (m_axis_tuser),
    .tlast   (m_axis_tlast)
  );

endmodule

// File: tb/tb_pp_pipeline_accel_mat2axis_sink.sv
// Bench for the mat2axis sink: queue-based FIFO/channel models and an expected-beat list.
module tb_pp_pipeline_accel_mat2axis_sink;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned DIM_W  = 32;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, ap_continue = 1'b1;
  logic ap_done, ap_idle, ap_ready;
  logic [DIM_W-1:0] rows_c_dout = '0, cols_c_dout = '0;
  logic rows_c_empty_n = 1'b0, cols_c_empty_n = 1'b0, rows_c_read, cols_c_read;
  logic [DATA_W-1:0] data_dout = '0, m_axis_tdata;
  logic data_empty_n = 1'b0, data_read;
  logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tuser, m_axis_tlast;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_mat2axis_sink #(
    .DATA_W(DATA_W),
    .DIM_W (DIM_W)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .rows_c_dout   (rows_c_dout),
    .rows_c_empty_n(rows_c_empty_n),
    .rows_c_read   (rows_c_read),
    .cols_c_dout   (cols_c_dout),
    .cols_c_empty_n(cols_c_empty_n),
    .cols_c_read   (cols_c_read),
    .data_dout     (data_dout),
    .data_empty_n  (data_empty_n),
    .data_read     (data_read),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              user;
    logic              last;
  } beat_t;

  logic [DATA_W-1:0] pix_q[$];
  beat_t             exp_q[$];
  int errors = 0, checks = 0;
  int step_n = 0, reads, rows_pops, cols_pops, beats, first_hs, last_hs, done_step;
  int ready_mode = 0, gap_at = -1, gap_left = 0;
  bit start_req = 0, dims_avail = 0, done_seen = 0, prev_rd = 0, gating = 0, saw_gap = 0;
  logic [DIM_W-1:0] rows_val = '0, cols_val = '0;

  task automatic drive_inputs();
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (step_n % 4 == 0) || (step_n % 4 == 3);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    gating = (reads == gap_at) && (gap_left > 0);
    if (gating) gap_left--;
    data_empty_n   = (pix_q.size() > 0) && !gating;
    data_dout      = (pix_q.size() > 0) ? pix_q[0] : '0;
    rows_c_empty_n = dims_avail;
    cols_c_empty_n = dims_avail;
    rows_c_dout    = rows_val;
    cols_c_dout    = cols_val;
    ap_start       = start_req && (rows_pops == 0);
  endtask

  // Observe one cycle at the falling edge, then advance the FIFO models past the rising edge.
  task automatic step();
    bit rd, hs;
    beat_t got;
    @(negedge ap_clk);
    checks++;
    if (rows_c_read !== cols_c_read) begin
      errors++;
      $display("FAIL dims_pop_pair: rows_c_read=%b cols_c_read=%b", rows_c_read, cols_c_read);
    end
    if (prev_rd) begin
      checks++;
      if (m_axis_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL pop_latency: tvalid=%b required 1", m_axis_tvalid);
      end
    end
    if (m_axis_tvalid === 1'b1) begin
      got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_beat: got %h required none", got);
      end else if (got !== exp_q[0]) begin
        errors++;
        $display("FAIL beat: got data=%h user=%b last=%b required data=%h user=%b last=%b",
                 got.data, got.user, got.last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
      end
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0) begin
      checks++;
      if (data_read !== 1'b0) begin
        errors++;
        $display("FAIL stall_read: data_read=%b required 0", data_read);
      end
    end
    if (m_axis_tvalid === 1'b0 && beats == 2 && reads == 2) saw_gap = 1;
    hs = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1);
    rd = (data_read === 1'b1);
    if (hs) begin
      beats++;
      if (first_hs < 0) first_hs = step_n;
      last_hs = step_n;
    end
    if (rows_c_read === 1'b1) begin
      rows_pops++;
      dims_avail = 0;
    end
    if (cols_c_read === 1'b1) cols_pops++;
    if (ap_done === 1'b1 && rows_pops > 0 && !done_seen) begin
      done_seen = 1;
      done_step = step_n;
    end
    @(posedge ap_clk);
    #1;
    if (rd) begin
      if (pix_q.size() > 0) void'(pix_q.pop_front());
      reads++;
    end
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    prev_rd = rd;
    step_n++;
    drive_inputs();
  endtask

  task automatic setup_frame(input int r, input int c, input bit seq);
    logic [DATA_W-1:0] p;
    beat_t b;
    pix_q.delete();
    exp_q.delete();
    for (int k = 0; k < r * c; k++) begin
      p = seq ? DATA_W'(k + 1) : DATA_W'($urandom);
      pix_q.push_back(p);
      b.data = p;
      b.user = (k == 0);
      b.last = ((k % c) == c - 1);
      exp_q.push_back(b);
    end
    rows_val = DIM_W'(r);
    cols_val = DIM_W'(c);
    dims_avail = 1;
    start_req = 1;
    reads = 0; rows_pops = 0; cols_pops = 0; beats = 0;
    first_hs = -1; last_hs = -1; done_step = -1; done_seen = 0; saw_gap = 0;
    drive_inputs();
  endtask

  task automatic wait_frame(input string name);
    for (int i = 0; i < 400 && !done_seen; i++) step();
    start_req = 0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ap_done not seen within 400 cycles", name);
    end
  endtask

  task automatic check_frame(input string name, input int r, input int c, input bit contig);
    int n = r * c;
    checks += 5;
    if (beats != n) begin errors++; $display("FAIL %s_beats: got %0d required %0d", name, beats, n); end
    if (reads != n) begin errors++; $display("FAIL %s_reads: got %0d required %0d", name, reads, n); end
    if (rows_pops != 1) begin errors++; $display("FAIL %s_rows_pops: got %0d required 1", name, rows_pops); end
    if (cols_pops != 1) begin errors++; $display("FAIL %s_cols_pops: got %0d required 1", name, cols_pops); end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d beats outstanding required 0", name, exp_q.size());
    end
    if (n > 0) begin
      checks++;
      if (done_step != last_hs + 1) begin
        errors++;
        $display("FAIL %s_done_timing: done at %0d required %0d", name, done_step, last_hs + 1);
      end
    end
    if (contig && n > 0) begin
      checks++;
      if (last_hs - first_hs != n - 1) begin
        errors++;
        $display("FAIL %s_throughput: span %0d required %0d", name, last_hs - first_hs, n - 1);
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    drive_inputs();
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, data_read, rows_c_read,
         cols_c_read, ap_done, ap_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%b tuser=%b tlast=%b tdata=%h rd=%b%b%b done=%b ready=%b required all 0",
               m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, data_read, rows_c_read,
               cols_c_read, ap_done, ap_ready);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();
    checks++;
    if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: ap_idle=%b required 1", ap_idle); end
  endtask

  task automatic test_basic();
    ready_mode = 0; gap_at = -1;
    setup_frame(2, 3, 1);
    wait_frame("basic");
    check_frame("basic", 2, 3, 1);
    step();
    checks++;
    if (ap_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: ap_done=%b required 0", ap_done); end
  endtask

  task automatic test_stall();
    ready_mode = 1; gap_at = -1;
    setup_frame(2, 3, 1);
    wait_frame("stall");
    check_frame("stall", 2, 3, 0);
  endtask

  task automatic test_gap();
    ready_mode = 0; gap_at = 2; gap_left = 4;
    setup_frame(1, 4, 1);
    wait_frame("gap");
    check_frame("gap", 1, 4, 0);
    checks++;
    if (!saw_gap) begin errors++; $display("FAIL gap_bubble: tvalid never dropped after beat 2, required a drop"); end
    gap_at = -1;
  endtask

  task automatic test_zero_dims();
    ready_mode = 0; gap_at = -1;
    setup_frame(0, 5, 0);
    wait_frame("zero");
    check_frame("zero", 0, 5, 0);
  endtask

  task automatic test_random();
    int r, c;
    for (int f = 0; f < 6; f++) begin
      r = $urandom_range(1, 4);
      c = $urandom_range(1, 4);
      ready_mode = 2;
      gap_at = $urandom_range(1, r * c);
      gap_left = $urandom_range(0, 3);
      setup_frame(r, c, 0);
      wait_frame("random");
      check_frame("random", r, c, 0);
    end
    gap_at = -1; ready_mode = 0;
  endtask

  task automatic test_continue();
    ready_mode = 0; gap_at = -1; ap_continue = 1'b0;
    setup_frame(2, 2, 0);
    wait_frame("hold_first");
    check_frame("hold_first", 2, 2, 0);
    setup_frame(1, 3, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks += 2;
      if (ap_done !== 1'b1) begin errors++; $display("FAIL hold_done: ap_done=%b required 1", ap_done); end
      if (rows_pops != 0) begin errors++; $display("FAIL hold_blocked: pops=%0d required 0", rows_pops); end
    end
    ap_continue = 1'b1;
    wait_frame("hold_second");
    check_frame("hold_second", 1, 3, 0);
  endtask

  task automatic test_reset_mid();
    ready_mode = 0; gap_at = -1;
    setup_frame(3, 3, 1);
    for (int i = 0; i < 100 && beats < 3; i++) step();
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, data_read, ap_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: tvalid=%b data_read=%b ap_done=%b required 000",
               m_axis_tvalid, data_read, ap_done);
    end
    start_req = 0; dims_avail = 0; prev_rd = 0;
    pix_q.delete();
    exp_q.delete();
    drive_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checks++;
    if (ap_idle !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: ap_idle=%b tvalid=%b required 1 0", ap_idle, m_axis_tvalid);
    end
    setup_frame(1, 2, 1);
    wait_frame("recover");
    check_frame("recover", 1, 2, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_zero_dims();
    test_random();
    test_continue();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_mat2axis_sink.md
Name: pp_pipeline_accel_mat2axis_sink

Overview:
Consumer end of the resize stage's output channels. It reads the frame dimensions from the rows/cols channel FIFOs, then drains rows*cols pixels from the resize output data FIFO and emits them as an AXI4-Stream video master. TUSER marks start of frame and TLAST marks end of line. It sits between the resize dataflow process and the DMA/VDMA write path, and uses ap_ctrl_chain block handshake.

Parameters:
DATA_W, 24, pixel width (3x8-bit RGB, one pixel per clock).
DIM_W, 32, width of the rows/cols channel words and of the internal counters.

Ports:
ap_clk  in  1  clock.
ap_rst_n  in  1  reset; asynchronous assert, active-low.
ap_start  in  1  block start (ap_ctrl_chain).
ap_done  out  1  block done.
ap_continue  in  1  clears held done.
ap_idle  out  1  idle indication.
ap_ready  out  1  ready for next start.
rows_c_dout  in  DIM_W  row-count channel data.
rows_c_empty_n  in  1  row-count channel non-empty.
rows_c_read  out  1  row-count channel pop.
cols_c_dout  in  DIM_W  column-count channel data.
cols_c_empty_n  in  1  column-count channel non-empty.
cols_c_read  out  1  column-count channel pop.
data_dout  in  DATA_W  pixel FIFO data.
data_empty_n  in  1  pixel FIFO non-empty.
data_read  out  1  pixel FIFO pop.
m_axis_tdata  out  DATA_W  output pixel.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
m_axis_tuser  out  1  start of frame; set on the first beat only.
m_axis_tlast  out  1  end of line.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): state IDLE, done_reg=0, counters=0, latched dims=0. tvalid/tuser/tlast/tdata=0. All FIFO reads=0. ap_done=0, ap_ready=0.
- FSM states: IDLE, DIMS, STREAM, DRAIN, DONE.
- IDLE:
  - ap_idle = ~ap_start.
  - If ap_start=1 and done_reg=0, go to DIMS.
  - If done_reg=1, start is blocked and the state stays IDLE.
- DIMS:
  - Wait until rows_c_empty_n and cols_c_empty_n are both 1. Pop both channels in the same cycle and latch rows and cols as unsigned values.
  - A channel is never popped alone.
  - If rows=0 or cols=0, go to DONE with no beats. Both channels have still been consumed.
  - Otherwise clear row/col counters and go to STREAM.
- STREAM, output register with one entry:
  - load = data_empty_n & (~tvalid | tready). data_read = load.
  - On load, capture tdata=data_dout, tuser=(row==0 & col==0), tlast=(col==cols-1), and set tvalid=1.
  - Counters: col increments; at cols-1, col wraps to 0 and row increments.
  - If tvalid&tready with no load, tvalid clears next cycle.
  - Load and handshake in the same cycle replace the register with no bubble: sustained 1 pixel/clock.
  - tdata, tuser and tlast stay stable while tvalid=1 and tready=0.
  - Loading the last pixel (row=rows-1, col=cols-1) moves to DRAIN. data_read is never asserted beyond rows*cols pops.
- Latency: a pixel popped in cycle N is presented with tvalid=1 in cycle N+1.
- DRAIN: no reads. When tvalid&tready, clear tvalid and go to DONE.
- DONE:
  - ap_done=1 and ap_ready=1 combinationally for one cycle; next state is IDLE.
  - If ap_continue=0 in that cycle, set done_reg=1.
- Held done: ap_done = done_state | done_reg. done_reg clears on any cycle with ap_continue=1.
- Mid-frame empty FIFO: no pop and no new beat. An in-flight beat is held until tready.
- Arithmetic: counters are DIM_W unsigned. The comparisons cols-1 and rows-1 are evaluated only when the corresponding dimension is non-zero.
- Reset mid-operation: immediate return to the reset state. A partial frame is abandoned and no done is issued.

Decomposition:
- Shared package pp_pipeline_accel_pkg holds:
  - FSM state enum.
  - DATA_W/DIM_W defaults.
  - ap_ctrl_chain helper constants.
- One natural sub-module, pp_pipeline_accel_axis_out_reg: the one-entry output register with load/hold logic (tdata/tuser/tlast/tvalid). The top keeps the FSM, counters and ctrl handshake.

Test Plan:
- rows=2, cols=3, pixels 0x000001..0x000006, tready=1 → 6 consecutive beats in order; tuser=1 on beat 1 only; tlast=1 on beats 3 and 6; ap_done pulses the cycle after the beat-6 handshake; exactly 6 data_read.
- Same frame with tready toggling 1,0,0,1 → no lost or duplicated pixels; tdata stable while stalled; data_read=0 while tvalid=1 & tready=0.
- data_empty_n deasserted for 4 cycles after pixel 2 of a 1x4 frame → tvalid drops after beat 2, resumes with pixel 3; tlast only on pixel 4.
- rows=0, cols=5 → rows_c_read and cols_c_read each pulse once together; zero beats; zero data_read; ap_done=1.
- ap_continue=0 at completion → ap_done stays 1; a new ap_start is ignored (no dims pop) until ap_continue=1, then the next frame runs.
- ap_rst_n asserted mid-frame (after 3 of 9 beats) → tvalid, data_read and ap_done are 0 immediately and asynchronously; after release, ap_idle=1 with ap_start=0.
